// File: rtl/sram_read_sense.sv
// sram_read_sense: read controller for one SRAM bit cell, with a threshold sense amp.
// Latency: dout_valid rises DEV_CYCLES+2 rising edges after the edge that accepts rd_req.
// Backpressure: dout/dout_err/dout_valid are held until rd_ack. rd_req is dropped while busy.
// Ports: clk, rst (async, active-high), rd_req/rd_ack handshake, vbl (sensed bit line),
//        vwl/vbl_pre (analog drive, decoded from state), dout/dout_err/dout_valid, busy.
module sram_read_sense #(
  parameter int  DEV_CYCLES = 3,
  parameter real VREF       = 0.75,
  parameter real VMARGIN    = 0.1
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic rd_ack,
  input  real  vbl,
  output real  vwl,
  output real  vbl_pre,
  output logic dout,
  output logic dout_err,
  output logic dout_valid,
  output logic busy
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  // Edges of the ambiguous band. A reading at exactly V_HI is a clean 1.
  // A reading at exactly V_LO is inside the band.
  localparam real V_HI = VREF + VMARGIN;
  localparam real V_LO = VREF - VMARGIN;

  // The counter counts down to 0, so DEVELOP lasts exactly DEV_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(DEV_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECH   = 3'd1,
    DEVELOP = 3'd2,
    SENSE   = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      dout       <= 1'b0;
      dout_err   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) state <= PRECH;
        end
        PRECH: begin
          cnt   <= CNT_LOAD;
          state <= DEVELOP;
        end
        DEVELOP: begin
          // The counter stops at 0 and never wraps.
          if (cnt == 4'd0) state <= SENSE;
          else             cnt   <= cnt - 4'd1;
        end
        SENSE: begin
          if (vbl >= V_HI) begin
            dout     <= 1'b1;
            dout_err <= 1'b0;
          end else if (vbl < V_LO) begin
            dout     <= 1'b0;
            dout_err <= 1'b0;
          end else begin
            dout     <= 1'b0;
            dout_err <= 1'b1;
          end
          dout_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          // dout and dout_err stay as they are after the ack. Only the valid flag drops.
          // This edge goes to IDLE, so a rd_req sampled on it is never accepted.
          if (rd_ack) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Drive is decoded from state alone. Reset forces state to IDLE, so both rails
  // drop to VSS as soon as rst asserts.
  always_comb begin
    vwl     = VSS;
    vbl_pre = VSS;
    case (state)
      PRECH: begin
        vwl     = VSS;
        vbl_pre = VDD;
      end
      DEVELOP, SENSE: begin
        vwl     = VDD;
        vbl_pre = VDD;
      end
      default: begin
        vwl     = VSS;
        vbl_pre = VSS;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_read_sense.sv
module tb_sram_read_sense;

  logic clk = 1'b0;
  logic rst = 1'b1;
  real  vbl = 0.0;

  logic req_a = 1'b0, ack_a = 1'b0;
  logic req_b = 1'b0, ack_b = 1'b0;

  real  vwl_a, vbl_pre_a, vwl_b, vbl_pre_b;
  logic dout_a, err_a, valid_a, busy_a;
  logic dout_b, err_b, valid_b, busy_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sram_read_sense #(.DEV_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .rd_req(req_a), .rd_ack(ack_a), .vbl(vbl),
    .vwl(vwl_a), .vbl_pre(vbl_pre_a), .dout(dout_a), .dout_err(err_a),
    .dout_valid(valid_a), .busy(busy_a)
  );

  sram_read_sense #(.DEV_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .rd_req(req_b), .rd_ack(ack_b), .vbl(vbl),
    .vwl(vwl_b), .vbl_pre(vbl_pre_b), .dout(dout_b), .dout_err(err_b),
    .dout_valid(valid_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full read on dut_a with a one-cycle rd_req pulse. E0 is the request edge.
  task automatic read_a(input real v, input logic ed, input logic ee, input string tag);
    vbl   = v;
    req_a = 1'b1;
    tick;                                   // E0 -> PRECH
    req_a = 1'b0;
    chk({tag, "_prech_pre"}, (vbl_pre_a == 1.5), 1);
    chk({tag, "_prech_wl"},  (vwl_a == 0.0), 1);
    chk({tag, "_busy"},      busy_a, 1);
    for (int i = 1; i <= 4; i++) begin      // E1..E3 DEVELOP, E4 SENSE
      tick;
      chk({tag, "_wl_hi"}, (vwl_a == 1.5), 1);
      chk({tag, "_early"}, valid_a, 0);
    end
    tick;                                   // E5 -> HOLD
    chk({tag, "_valid"}, valid_a, 1);
    chk({tag, "_dout"},  dout_a, ed);
    chk({tag, "_err"},   err_a, ee);
    chk({tag, "_wl_lo"}, (vwl_a == 0.0), 1);
    ack_a = 1'b1;
    tick;
    ack_a = 1'b0;
    chk({tag, "_ackv"},   valid_a, 0);
    chk({tag, "_ackb"},   busy_a, 0);
    chk({tag, "_keepd"},  dout_a, ed);
    chk({tag, "_keepe"},  err_a, ee);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_valid", valid_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_dout",  {dout_a, err_a}, 2'b00);
    chk("rst_vwl",   (vwl_a == 0.0 && vbl_pre_a == 0.0), 1);
    chk("rst_b",     {valid_b, busy_b}, 2'b00);
    rst = 1'b0;
    tick;
    chk("idle_busy", busy_a, 0);

    // Basic reads and the ambiguous band
    read_a(1.5,  1'b1, 1'b0, "r1");
    read_a(0.0,  1'b0, 1'b0, "r0");
    read_a(0.72, 1'b0, 1'b1, "amb");
    read_a(0.85, 1'b1, 1'b0, "vhi");
    read_a(0.60, 1'b0, 1'b0, "vlo");

    // rd_ack held outside HOLD has no effect
    vbl   = 1.5;
    ack_a = 1'b1;
    req_a = 1'b1;
    tick;
    req_a = 1'b0;
    repeat (4) tick;
    tick;                                   // E5
    chk("ackout_valid", valid_a, 1);
    chk("ackout_dout",  dout_a, 1);
    tick;
    chk("ackout_clr",   valid_a, 0);
    ack_a = 1'b0;
    tick;

    // Handshake with rd_req held high throughout
    vbl   = 0.0;
    req_a = 1'b1;
    tick;                                   // E0
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("hs_early", valid_a, 0);
    end
    tick;                                   // E5
    chk("hs_valid", valid_a, 1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hs_hold", {valid_a, busy_a}, 2'b11);
    end
    ack_a = 1'b1;
    tick;                                   // HOLD exit with rd_req still high
    ack_a = 1'b0;
    chk("hs_exit_v", valid_a, 0);
    chk("hs_norest", busy_a, 0);
    tick;                                   // rd_req is accepted on a later IDLE edge
    req_a = 1'b0;
    chk("hs_restart", busy_a, 1);
    repeat (4) tick;
    tick;
    chk("hs_2nd_valid", valid_a, 1);
    ack_a = 1'b1;
    tick;
    ack_a = 1'b0;
    chk("hs_2nd_idle", busy_a, 0);

    // Reset in the middle of DEVELOP
    vbl   = 1.5;
    req_a = 1'b1;
    tick;                                   // E0
    req_a = 1'b0;
    tick;                                   // E1
    tick;                                   // E2 (DEVELOP)
    chk("mid_dev_wl", (vwl_a == 1.5), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wl",   (vwl_a == 0.0 && vbl_pre_a == 0.0), 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_v",    valid_a, 0);
    tick;
    tick;
    chk("mid_rst_nov",  valid_a, 0);
    rst = 1'b0;
    tick;
    read_a(1.5, 1'b1, 1'b0, "postrst");

    // DEV_CYCLES = 1. rd_req pulses during PRECH and SENSE are dropped.
    vbl   = 1.5;
    req_b = 1'b1;
    tick;                                   // E0 -> PRECH; rd_req also seen at E1
    tick;                                   // E1 -> DEVELOP
    req_b = 1'b0;
    chk("b_busy", busy_b, 1);
    chk("b_wl",   (vwl_b == 1.5), 1);
    tick;                                   // E2 -> SENSE
    chk("b_early", valid_b, 0);
    req_b = 1'b1;
    tick;                                   // E3 -> HOLD
    req_b = 1'b0;
    chk("b_valid", valid_b, 1);
    chk("b_dout",  {dout_b, err_b}, 2'b10);
    ack_b = 1'b1;
    tick;
    ack_b = 1'b0;
    chk("b_ack", {valid_b, busy_b}, 2'b00);
    tick;
    chk("b_noqueue", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_read_sense.md
SRAM_READ_SENSE -- requirements
Module: sram_read_sense

Interface
REQ-001 SHALL have parameter DEV_CYCLES, default 3: number of bit-line develop cycles, integer, legal range 1..15.
REQ-002 SHALL have parameter VREF, default 0.75: real sense threshold in volts.
REQ-003 SHALL have parameter VMARGIN, default 0.1: real half-width of the ambiguous band around VREF, in volts.
REQ-004 SHALL use constants VDD = 1.5 and VSS = 0.0, both real.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rd_req, input, 1 bit: read request.
REQ-008 SHALL have port rd_ack, input, 1 bit: consumer accepts dout.
REQ-009 SHALL have port vbl, input, real: bit-line voltage from the access-transistor source.
REQ-010 SHALL have port vwl, output, real: word-line drive to the access-transistor gate.
REQ-011 SHALL have port vbl_pre, output, real: precharge drive to the access-transistor drain.
REQ-012 SHALL have port dout, output, 1 bit: sensed data.
REQ-013 SHALL have port dout_err, output, 1 bit: sensed voltage fell inside the ambiguous band.
REQ-014 SHALL have port dout_valid, output, 1 bit: dout and dout_err are valid.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, PRECH, DEVELOP, SENSE and HOLD.
REQ-017 IDLE: rd_req=1 at a rising edge -> PRECH; otherwise remain in IDLE.
REQ-018 PRECH SHALL last exactly 1 cycle, then go to DEVELOP; entering DEVELOP loads the develop counter with DEV_CYCLES-1.
REQ-019 DEVELOP SHALL decrement the counter each cycle and go to SENSE on the edge where the counter is 0, so DEVELOP lasts exactly DEV_CYCLES cycles.
REQ-020 SENSE SHALL last exactly 1 cycle; on the edge leaving SENSE it registers dout, dout_err and dout_valid=1 and goes to HOLD.
REQ-021 Sense decision, taken on that edge:
- vbl >= VREF+VMARGIN: dout=1, dout_err=0.
- vbl < VREF-VMARGIN: dout=0, dout_err=0.
- otherwise: dout=0, dout_err=1.
REQ-022 HOLD: dout, dout_err and dout_valid SHALL stay stable until rd_ack=1 at a rising edge; that edge clears dout_valid and returns to IDLE.
REQ-023 In HOLD, dout and dout_err SHALL retain their values after dout_valid clears until the next SENSE exit.
REQ-024 rd_ack outside HOLD SHALL be ignored.
REQ-025 rd_req while busy=1 SHALL be ignored, not queued.
REQ-026 rd_req=1 on the same edge that HOLD exits to IDLE SHALL be ignored; a new read needs rd_req=1 at a later edge in IDLE.
REQ-027 Latency: with the request edge as E0, dout_valid SHALL rise at edge E(DEV_CYCLES+2), which is E5 for the default.
REQ-028 Analog drive, decoded from state only, per state (vwl / vbl_pre):
- IDLE: VSS / VSS.
- PRECH: VSS / VDD.
- DEVELOP: VDD / VDD.
- SENSE: VDD / VDD.
- HOLD: VSS / VSS.
REQ-029 vwl SHALL never equal VDD while the FSM is in PRECH, IDLE or HOLD.
REQ-030 The develop counter SHALL be 4 bits and unsigned; it SHALL never wrap below 0.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE and counter=0;
- dout=0, dout_err=0, dout_valid=0, busy=0;
- vwl=VSS, vbl_pre=VSS.
REQ-032 rst asserted mid-operation, in any state, SHALL abort the read with no dout_valid pulse.
REQ-033 After rst deasserts, the first rd_req=1 edge SHALL start a normal read.

Verification
REQ-034 Basic read of a 1: DEV_CYCLES=3, vbl=1.5 driven during DEVELOP/SENSE, rd_req pulsed at E0 -> vwl=1.5 from E1 to E3, dout_valid=1 at E5 with dout=1 and dout_err=0, held until rd_ack.
REQ-035 Basic read of a 0: vbl=0.0 -> dout=0, dout_err=0 at E5.
REQ-036 Ambiguous band: vbl=0.72 -> dout=0, dout_err=1, dout_valid=1; vbl=0.85 -> dout=1, dout_err=0.
REQ-037 Handshake: hold rd_ack=0 for 10 cycles -> dout_valid stays 1 and busy stays 1; rd_ack=1 -> dout_valid=0 next edge; rd_req held high throughout -> exactly one read per IDLE entry, and no restart on the HOLD exit edge.
REQ-038 Reset mid-operation: assert rst during DEVELOP -> vwl=0.0, busy=0 and dout_valid=0 immediately; deassert rst and pulse rd_req -> a full read completes with correct latency.
REQ-039 Boundary: DEV_CYCLES=1 -> dout_valid at E3; rd_req pulsed during PRECH and SENSE -> ignored.
